ysyx_22041752_sram_resp: RTL and testbench

//  SRAM-side responder for the sram_req/sram_ready/sram_valid handshake driven by the data-side IO bridge.

---
 rtl/ysyx_22041752_sram_resp_if.sv | 28 ++
 rtl/ysyx_22041752_sram_resp.sv | 159 +++++++++++++++
 tb/tb_ysyx_22041752_sram_resp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041752_sram_resp_if.sv
// Request/response bus between the IO bridge (master) and the SRAM responder (slave).
// sram_req is held with addr/wen/wdata stable until a one-cycle sram_ready accept pulse is seen.
// After that, a single one-cycle sram_valid pulse completes the transaction, with sram_rdata qualifying it.
// sram_rdata then holds until the next completion, and acc_err is a sticky out-of-range flag.
interface ysyx_22041752_sram_resp_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64,
  parameter int WEN_WD  = 8
);
  logic               sram_req;
  logic               sram_ready;
  logic [WEN_WD-1:0]  sram_wen;
  logic [ADDR_WD-1:0] sram_addr;
  logic [DATA_WD-1:0] sram_wdata;
  logic [DATA_WD-1:0] sram_rdata;
  logic               sram_valid;
  logic               acc_err;

  modport master (
    output sram_req, sram_wen, sram_addr, sram_wdata,
    input  sram_ready, sram_rdata, sram_valid, acc_err
  );

  modport slave (
    input  sram_req, sram_wen, sram_addr, sram_wdata,
    output sram_ready, sram_rdata, sram_valid, acc_err
  );
endinterface

// File: rtl/ysyx_22041752_sram_resp.sv
// SRAM responder: accepts one request at a time, completes it after a fixed latency,
// and performs byte-masked writes or full-word reads on an internal word array.
module ysyx_22041752_sram_resp #(
  parameter int                 ADDR_WD   = 32,
  parameter int                 DATA_WD   = 64,
  parameter int                 WEN_WD    = 8,
  parameter int                 DEPTH     = 1024,
  parameter logic [ADDR_WD-1:0] BASE_ADDR = 32'ha000_0000,
  parameter int                 LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  ysyx_22041752_sram_resp_if.slave      bus,
  output logic [1:0]                    o_dbg_state
);

  localparam int BYTES    = DATA_WD / 8;
  localparam int OFF_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WD   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_WD-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_WD'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_WD-1:0]   r_cnt;
  logic [CNT_WD-1:0]   w_cnt_nxt;
  logic                w_latch;
  logic                w_access;

  logic [ADDR_WD-1:0]  r_addr;
  logic [WEN_WD-1:0]   r_wen;
  logic [DATA_WD-1:0]  r_wdata;
  logic [DATA_WD-1:0]  r_rdata;
  logic                r_acc_err;

  logic [DATA_WD-1:0]  r_mem [DEPTH];

  logic [ADDR_WD-1:0]  w_off;
  logic [ADDR_WD-1:0]  w_idx_full;
  logic [IDX_WD-1:0]   w_idx;
  logic                w_in_range;
  logic                w_is_write;
  logic [DATA_WD-1:0]  w_rd_word;
  logic [DATA_WD-1:0]  w_merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The array access fires on the edge that leaves the latency window toward DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sram_req) begin
          w_state_nxt = S_ACK;
          w_latch     = 1'b1;
        end
      end
      S_ACK: begin
        if (LATENCY == 0) begin
          w_state_nxt = S_DONE;
          w_access    = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_WD'(1);
        end else begin
          w_state_nxt = S_DONE;
          w_access    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_addr  <= bus.sram_addr;
      r_wen   <= bus.sram_wen;
      r_wdata <= bus.sram_wdata;
    end
  end

  // Unsigned subtraction wraps for addresses below the base, so the explicit >= test is required.
  assign w_off      = r_addr - BASE_ADDR;
  assign w_idx_full = w_off >> OFF_BITS;
  assign w_in_range = (r_addr >= BASE_ADDR) && (w_idx_full < ADDR_WD'(DEPTH));
  assign w_idx      = w_idx_full[IDX_WD-1:0];
  assign w_is_write = (r_wen != '0);
  assign w_rd_word  = r_mem[w_idx];

  always_comb begin
    w_merged = w_rd_word;
    for (int i = 0; i < BYTES; i++) begin
      if (r_wen[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && w_in_range && w_is_write) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata   <= '0;
      r_acc_err <= 1'b0;
    end else if (w_access) begin
      if (!w_in_range) begin
        r_rdata   <= '0;
        r_acc_err <= 1'b1;
      end else if (w_is_write) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign bus.sram_ready = (r_state == S_ACK);
  assign bus.sram_valid = (r_state == S_DONE);
  assign bus.sram_rdata = r_rdata;
  assign bus.acc_err    = r_acc_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ysyx_22041752_sram_resp.sv
// Bench for the SRAM responder: directed cases, latency variants and randomized traffic,
// with a scoreboard queue fed by the driver and drained by a valid-triggered monitor.
module tb_ysyx_22041752_sram_resp;

  localparam int          ADDR_WD = 32;
  localparam int          DATA_WD = 64;
  localparam int          WEN_WD  = 8;
  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'ha000_0000;
  localparam longint unsigned BASE_L = 64'ha000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ysyx_22041752_sram_resp_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD)) bus ();
  ysyx_22041752_sram_resp_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD)) bus_l0 ();
  ysyx_22041752_sram_resp_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD)) bus_l5 ();
  logic [1:0] dbg, dbg_l0, dbg_l5;

  ysyx_22041752_sram_resp #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg));
  ysyx_22041752_sram_resp #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .LATENCY(0)) dut_l0 (.clk(clk), .reset(reset), .bus(bus_l0), .o_dbg_state(dbg_l0));
  ysyx_22041752_sram_resp #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .WEN_WD(WEN_WD), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .LATENCY(5)) dut_l5 (.clk(clk), .reset(reset), .bus(bus_l5), .o_dbg_state(dbg_l5));

  int n_checks  = 0;
  int n_fail    = 0;
  int n_accepts = 0;
  int n_issued  = 0;
  int n_ready   = 0;
  int n_valid   = 0;

  logic [64:0] exp_q[$];
  logic [63:0] model_mem [int];
  bit          model_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: word array keyed by word index, sticky error flag.
  function automatic logic [64:0] model_apply(input logic [7:0] wen, input logic [31:0] addr,
                                              input logic [63:0] wdata);
    longint unsigned la = addr;
    int idx;
    logic [63:0] w;
    if (!(la >= BASE_L && (la - BASE_L) < longint'(DEPTH) * 8)) begin
      model_err = 1'b1;
      return {1'b1, 64'h0};
    end
    idx = int'((la - BASE_L) / 8);
    if (wen == 8'h00) return {model_err, model_mem[idx]};
    w = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
    for (int b = 0; b < 8; b++) if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
    model_mem[idx] = w;
    return {model_err, 64'h0};
  endfunction

  task automatic issue(input logic [7:0] wen, input logic [31:0] addr, input logic [63:0] wdata,
                       input bit track);
    bit got = 1'b0;
    if (track) begin
      exp_q.push_back(model_apply(wen, addr, wdata));
      n_issued++;
    end
    n_accepts++;
    bus.sram_req   = 1'b1;
    bus.sram_wen   = wen;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (bus.sram_ready) got = 1'b1;
    end
    check("ready_seen", 64'(got), 64'd1);
    bus.sram_req = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [64:0] e;
    if (bus.sram_ready) n_ready++;
    if (bus.sram_valid) begin
      n_valid++;
      check("valid_width", 64'(prev_valid), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected no completion at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.sram_rdata, e[63:0]);
        check("acc_err", 64'(bus.acc_err), 64'(e[64]));
      end
    end
    prev_valid = bus.sram_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0 = -1, v0 = -1, rc0 = 0, vc0 = 0;
    int r5 = -1, v5 = -1, rc5 = 0, vc5 = 0;
    logic [31:0] a;
    logic [7:0]  wen;

    bus.sram_req = 1'b0; bus.sram_wen = '0; bus.sram_addr = '0; bus.sram_wdata = '0;
    bus_l0.sram_req = 1'b0; bus_l0.sram_wen = 8'hFF; bus_l0.sram_addr = BASE; bus_l0.sram_wdata = '0;
    bus_l5.sram_req = 1'b0; bus_l5.sram_wen = 8'hFF; bus_l5.sram_addr = BASE; bus_l5.sram_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.sram_ready), 64'd0);
    check("rst_valid", 64'(bus.sram_valid), 64'd0);
    check("rst_rdata", bus.sram_rdata, 64'd0);
    check("rst_acc_err", 64'(bus.acc_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full write then readback; partial-mask merge.
    issue(8'hFF, BASE + 32'h10, 64'h0123_4567_89AB_CDEF, 1'b1);
    issue(8'h00, BASE + 32'h10, 64'h0, 1'b1);
    drain();
    issue(8'hFF, BASE + 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(8'h0F, BASE + 32'h20, 64'h0, 1'b1);
    issue(8'h00, BASE + 32'h20, 64'h0, 1'b1);
    drain();
    check("merge_model", model_mem[4], 64'hFFFF_FFFF_0000_0000);

    // Latency-0 and latency-5 variants; cycle 0 ends at the edge that samples req.
    bus_l0.sram_req = 1'b1;
    bus_l5.sram_req = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus_l0.sram_ready) begin rc0++; if (r0 < 0) r0 = cyc; bus_l0.sram_req = 1'b0; end
      if (bus_l0.sram_valid) begin vc0++; if (v0 < 0) v0 = cyc; end
      if (bus_l5.sram_ready) begin rc5++; if (r5 < 0) r5 = cyc; bus_l5.sram_req = 1'b0; end
      if (bus_l5.sram_valid) begin vc5++; if (v5 < 0) v5 = cyc; end
    end
    check("l0_ready_cycle", 64'(r0), 64'd1);
    check("l0_valid_cycle", 64'(v0), 64'd2);
    check("l0_ready_width", 64'(rc0), 64'd1);
    check("l0_valid_width", 64'(vc0), 64'd1);
    check("l5_ready_cycle", 64'(r5), 64'd1);
    check("l5_valid_cycle", 64'(v5), 64'd7);
    check("l5_ready_width", 64'(rc5), 64'd1);
    check("l5_valid_width", 64'(vc5), 64'd1);

    // Back-to-back reads from the bridge.
    issue(8'h00, BASE + 32'h20, 64'h0, 1'b1);
    issue(8'h00, BASE + 32'h10, 64'h0, 1'b1);
    drain();

    // Randomized traffic over a prefilled 16-word window, with occasional out-of-range hits.
    for (int i = 0; i < 16; i++) issue(8'hFF, BASE + 32'(8 * i), {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 32'(8 * $urandom_range(1, 100));
        else a = BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 1000));
      end else begin
        a = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
      end
      wen = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      issue(wen, a, {$urandom, $urandom}, 1'b1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    // Out-of-range read and write, then confirm the array was not touched.
    issue(8'h00, BASE + 32'(DEPTH * 8), 64'h0, 1'b1);
    issue(8'hFF, BASE - 32'h8, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    issue(8'h00, BASE + 32'h10, 64'h0, 1'b1);
    drain();
    check("acc_err_sticky", 64'(bus.acc_err), 64'd1);

    // Reset during the latency window abandons the write.
    issue(8'hFF, BASE + 32'h10, 64'h5555_AAAA_5555_AAAA, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.sram_ready), 64'd0);
    check("mid_rst_valid", 64'(bus.sram_valid), 64'd0);
    check("mid_rst_rdata", bus.sram_rdata, 64'd0);
    check("mid_rst_acc_err", 64'(bus.acc_err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_err = 1'b0;
    repeat (4) @(negedge clk);
    issue(8'h00, BASE + 32'h10, 64'h0, 1'b1);
    drain();

    repeat (10) @(negedge clk);
    check("ready_count", 64'(n_ready), 64'(n_accepts));
    check("valid_count", 64'(n_valid), 64'(n_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
